fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL provide parameter RESET_ADDR, default 32'h00000000, the first fetch address after reset.
REQ-002 The block SHALL provide parameter DEPTH, default 4, the instruction queue depth; legal values are powers of two from 2 to 16.
REQ-003 The block SHALL use clock i_clk and reset i_rst; i_rst is synchronous and active-high.
REQ-004 i_clk  input  1  clock; all state updates on rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_redirect  input  1  flush queue and restart fetch at i_redirect_pc.
REQ-007 i_redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-008 o_imem_req  output  1  fetch request valid.
REQ-009 o_imem_raddr  output  32  fetch address, word aligned.
REQ-010 i_imem_ready  input  1  memory accepts the request this cycle.
REQ-011 i_imem_rvalid  input  1  response valid; responses return in request order, at least 1 cycle after acceptance.
REQ-012 i_imem_rdata  input  32  response instruction word.
REQ-013 o_inst_valid  output  1  queue head valid toward decode.
REQ-014 o_inst  output  32  head instruction.
REQ-015 o_inst_pc  output  32  address of head instruction.
REQ-016 i_inst_ready  input  1  decode accepts head this cycle.

Function
REQ-017 Internal state SHALL be: fetch PC, a FIFO of DEPTH {pc, inst} entries with count, an outstanding-request counter, a PC FIFO for in-flight addresses, and a drop counter; each counter is clog2(DEPTH)+1 bits wide.
REQ-018 o_imem_req SHALL be 1 iff not in reset, i_redirect=0, and count+outstanding < DEPTH.
REQ-019 o_imem_raddr SHALL equal the fetch PC.
REQ-020 A request SHALL be accepted when o_imem_req=1 and i_imem_ready=1: fetch PC += 4 (wraps modulo 2^32), outstanding +1, and the address is pushed to the in-flight PC FIFO.
REQ-021 When i_imem_ready=0, o_imem_req and o_imem_raddr SHALL hold unchanged until acceptance or redirect.
REQ-022 On i_imem_rvalid with drop=0 and i_redirect=0, {in-flight PC, i_imem_rdata} SHALL be enqueued; outstanding -1.
REQ-023 On i_imem_rvalid with drop>0, the data SHALL be discarded; drop -1, outstanding -1, and the in-flight PC pops.
REQ-024 i_imem_rvalid with outstanding=0 SHALL be ignored with no state change.
REQ-025 o_inst_valid SHALL be (count>0) AND i_redirect=0; o_inst and o_inst_pc SHALL present the head entry.
REQ-026 A dequeue SHALL occur when o_inst_valid=1 and i_inst_ready=1; enqueue and dequeue in the same cycle SHALL leave count unchanged.
REQ-027 There SHALL be no bypass: a response is visible on o_inst_valid no earlier than the cycle after it arrives.
REQ-028 On i_redirect=1: the queue SHALL be emptied, no request issued, fetch PC <= {i_redirect_pc[31:2],2'b00}, any response this cycle discarded, and drop <= outstanding minus (1 if i_imem_rvalid this cycle).
REQ-029 Back-to-back redirects SHALL each apply; the last one determines the fetch PC.
REQ-030 The credit rule in REQ-018 SHALL guarantee that the queue never overflows; enqueue when full is unreachable.

Reset
REQ-031 While i_rst=1: fetch PC=RESET_ADDR, count=0, outstanding=0, drop=0, o_imem_req=0, o_inst_valid=0; all other inputs ignored.
REQ-032 Reset SHALL override redirect and all handshakes; requests in flight at reset are forgotten and the environment SHALL not return them.
REQ-033 In the first cycle after reset release, o_imem_req SHALL be 1 with o_imem_raddr=RESET_ADDR.

Verification
REQ-034 Streaming: DEPTH=4, ready=1, 1-cycle response, decode ready=1 -> addresses 0,4,8,... issued every cycle; o_inst_pc 0 first valid 2 cycles after reset release; one instruction per cycle thereafter.
REQ-035 Backpressure: i_inst_ready=0 -> exactly 4 requests issued, o_imem_req drops to 0, queue holds PCs 0..C in order; raising ready resumes issue the next cycle.
REQ-036 Redirect with in-flight: 3 outstanding, i_redirect_pc=32'h103 -> next request at 32'h100, 3 late responses discarded, first o_inst_pc=32'h100.
REQ-037 Memory stall: i_imem_ready=0 for 5 cycles -> o_imem_raddr stable and o_imem_req held at 1; no PC skipped.
REQ-038 Wrap and reset: RESET_ADDR=32'hFFFFFFF8 -> PCs FFFFFFF8, FFFFFFFC, 00000000; i_rst mid-stream -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word-aligned fetches under a credit limit, tracks in-flight
// addresses, buffers returned words in a FIFO toward decode and drops stale responses on redirect.
module fetch_queue #(
    parameter logic [31:0] RESET_ADDR = 32'h00000000,
    parameter int unsigned DEPTH      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_raddr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] out_q, out_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic [PtrW-1:0] q_head_q, q_head_d, q_tail_q, q_tail_d;
    logic [PtrW-1:0] f_head_q, f_head_d, f_tail_q, f_tail_d;

    logic [31:0] q_pc_q   [DEPTH];
    logic [31:0] q_inst_q [DEPTH];
    logic [31:0] f_pc_q   [DEPTH];

    logic credit_ok;
    logic accept;
    logic resp;
    logic keep;
    logic deq;

    always_comb begin
        // Queued entries plus in-flight requests never exceed DEPTH, so enqueue cannot overflow.
        credit_ok    = ({1'b0, cnt_q} + {1'b0, out_q}) < (CntW + 1)'(DEPTH);
        o_imem_req   = !i_rst && !i_redirect && credit_ok;
        o_imem_raddr = fetch_pc_q;
        accept       = o_imem_req && i_imem_ready;
        resp         = !i_rst && i_imem_rvalid && (out_q != '0);
        keep         = resp && (drop_q == '0) && !i_redirect;
        o_inst_valid = !i_rst && !i_redirect && (cnt_q != '0);
        o_inst       = q_inst_q[q_head_q];
        o_inst_pc    = q_pc_q[q_head_q];
        deq          = o_inst_valid && i_inst_ready;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        cnt_d      = cnt_q;
        out_d      = out_q + CntW'(accept) - CntW'(resp);
        drop_d     = drop_q;
        q_head_d   = q_head_q;
        q_tail_d   = q_tail_q;
        f_head_d   = resp ? f_head_q + PtrW'(1) : f_head_q;
        f_tail_d   = accept ? f_tail_q + PtrW'(1) : f_tail_q;

        if (i_redirect) begin
            fetch_pc_d = {i_redirect_pc[31:2], 2'b00};
            cnt_d      = '0;
            q_head_d   = '0;
            q_tail_d   = '0;
            // Everything still in flight after this cycle belongs to the old stream.
            drop_d     = out_q - CntW'(resp);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp && (drop_q != '0)) begin
                drop_d = drop_q - CntW'(1);
            end
            cnt_d = cnt_q + CntW'(keep) - CntW'(deq);
            if (keep) begin
                q_tail_d = q_tail_q + PtrW'(1);
            end
            if (deq) begin
                q_head_d = q_head_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_q <= RESET_ADDR;
            cnt_q      <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            q_head_q   <= '0;
            q_tail_q   <= '0;
            f_head_q   <= '0;
            f_tail_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            q_head_q   <= q_head_d;
            q_tail_q   <= q_tail_d;
            f_head_q   <= f_head_d;
            f_tail_q   <= f_tail_d;
        end
    end

    // Storage arrays need no reset; the pointers and counts define what is valid.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            f_pc_q[f_tail_q] <= fetch_pc_q;
        end
        if (keep) begin
            q_pc_q[q_tail_q]   <= f_pc_q[f_head_q];
            q_inst_q[q_tail_q] <= i_imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue: the bench plays the memory, models program order
// and credit usage with queues, and a separate monitor checks every instruction taken by decode.
module tb_fetch_queue;

    localparam logic [31:0] RST_ADDR = 32'h00000000;
    localparam int          DEPTH    = 4;

    logic        clk;
    logic        i_rst;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_raddr;
    logic        i_imem_ready;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_inst_ready;

    fetch_queue #(
        .RESET_ADDR(RST_ADDR),
        .DEPTH     (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_imem_req   (o_imem_req),
        .o_imem_raddr (o_imem_raddr),
        .i_imem_ready (i_imem_ready),
        .i_imem_rvalid(i_imem_rvalid),
        .i_imem_rdata (i_imem_rdata),
        .o_inst_valid (o_inst_valid),
        .o_inst       (o_inst),
        .o_inst_pc    (o_inst_pc),
        .i_inst_ready (i_inst_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          rdy;
    } mem_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    mem_t mem_q[$];   // requests accepted by memory, oldest first
    exp_t sb_q[$];    // instructions decode should see, in program order

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] model_pc;
    int          n_arr;   // responses of the current stream sitting in the queue

    // knobs: percentages except p_rst (per mille)
    int p_rst, p_redir, p_ready, p_rv, p_spur, p_iready;
    bit          f_redir, f_rst;
    logic [31:0] f_rpc;

    bit          d_rst, d_redir, d_ready, d_rvalid, d_real, d_iready;
    logic [31:0] d_rpc, d_rdata;
    bit          exp_req, exp_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h13579BDF;
    endfunction

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    endtask

    task automatic set_knobs(input int rst, input int redir, input int rdy, input int rv,
                             input int spur, input int irdy);
        p_rst = rst; p_redir = redir; p_ready = rdy; p_rv = rv; p_spur = spur; p_iready = irdy;
    endtask

    task automatic drive();
        d_rst   = f_rst || (int'($urandom_range(999)) < p_rst);
        d_redir = f_redir || pct(p_redir);
        if (f_redir) d_rpc = f_rpc;
        else if (pct(30)) d_rpc = 32'hFFFFFFF0 | 32'($urandom_range(15));
        else d_rpc = $urandom;
        d_ready  = pct(p_ready);
        d_iready = pct(p_iready);
        d_real   = !d_rst && (mem_q.size() > 0) && (mem_q.size() > 0 ? mem_q[0].rdy <= cyc : 1'b0)
                   && pct(p_rv);
        d_rvalid = d_real || ((mem_q.size() == 0) && pct(p_spur));
        d_rdata  = d_real ? mem_word(mem_q[0].addr) : $urandom;
        exp_req   = !d_rst && !d_redir && (n_arr + mem_q.size() < DEPTH);
        exp_valid = !d_rst && !d_redir && (n_arr > 0);
        f_redir = 1'b0;
        f_rst   = 1'b0;
        i_rst         = d_rst;
        i_redirect    = d_redir;
        i_redirect_pc = d_rpc;
        i_imem_ready  = d_ready;
        i_imem_rvalid = d_rvalid;
        i_imem_rdata  = d_rdata;
        i_inst_ready  = d_iready;
    endtask

    // Apply what the last clock edge did to the abstract model.
    task automatic update();
        mem_t h;
        cyc++;
        if (d_rst) begin
            model_pc = RST_ADDR;
            n_arr    = 0;
            mem_q.delete();
            sb_q.delete();
        end else begin
            h.stale = 1'b1;
            if (d_real) h = mem_q.pop_front();
            if (d_redir) begin
                n_arr = 0;
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                model_pc = {d_rpc[31:2], 2'b00};
                sb_q.delete();
            end else begin
                if (d_real && !h.stale) n_arr++;
                if (exp_valid && d_iready) n_arr--;
                if (exp_req && d_ready) begin
                    mem_q.push_back('{addr: model_pc, stale: 1'b0, rdy: cyc + 1});
                    sb_q.push_back('{pc: model_pc, inst: mem_word(model_pc)});
                    model_pc = model_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        update();
        drive();
        @(negedge clk);
        chk("imem_req", {31'd0, o_imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_raddr", o_imem_raddr, model_pc);
        chk("inst_valid", {31'd0, o_inst_valid}, {31'd0, exp_valid});
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Monitor: every instruction decode takes must be the next one in program order.
    always @(negedge clk) begin
        exp_t e;
        if (o_inst_valid && i_inst_ready) begin
            if (sb_q.size() == 0) begin
                chk("inst_valid_empty", {31'd0, o_inst_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("inst_pc", o_inst_pc, e.pc);
                chk("inst", o_inst, e.inst);
            end
        end
    end

    initial begin
        model_pc = RST_ADDR;
        n_arr    = 0;
        f_redir  = 1'b0;
        f_rst    = 1'b0;
        f_rpc    = '0;
        d_rst = 1'b1; d_redir = 1'b0; d_ready = 1'b0; d_rvalid = 1'b0; d_real = 1'b0;
        d_iready = 1'b0; d_rpc = '0; d_rdata = '0; exp_req = 1'b0; exp_valid = 1'b0;
        i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0; i_imem_ready = 1'b0;
        i_imem_rvalid = 1'b0; i_imem_rdata = '0; i_inst_ready = 1'b0;

        // Reset, then full-rate streaming with 1-cycle memory.
        set_knobs(0, 0, 100, 100, 0, 100);
        repeat (3) begin f_rst = 1'b1; cycle(); end
        run(20);
        // Decode backpressure then release.
        set_knobs(0, 0, 100, 100, 0, 0);
        run(10);
        set_knobs(0, 0, 100, 100, 0, 100);
        run(10);
        // Redirect with requests in flight; late responses must be dropped.
        set_knobs(0, 0, 100, 0, 0, 100);
        run(3);
        f_redir = 1'b1; f_rpc = 32'h00000103;
        cycle();
        set_knobs(0, 0, 100, 100, 0, 100);
        run(10);
        // Memory stall.
        set_knobs(0, 0, 0, 100, 0, 100);
        run(5);
        set_knobs(0, 0, 100, 100, 0, 100);
        run(5);
        // Address wrap across 2^32.
        f_redir = 1'b1; f_rpc = 32'hFFFFFFF8;
        cycle();
        run(10);
        // Reset mid-stream.
        f_rst = 1'b1;
        cycle();
        run(10);
        // Randomized traffic including spurious responses, redirects and resets.
        for (int blk = 0; blk < 60; blk++) begin
            set_knobs(int'($urandom_range(4)), int'($urandom_range(8)),
                      int'($urandom_range(20, 100)), int'($urandom_range(20, 100)),
                      int'($urandom_range(15)), int'($urandom_range(10, 100)));
            run(50);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
